// File: rtl/mc_control_if.sv
// ---------------------------------------------------------------------------
// mc_control_if
//   Bundles the multicycle MIPS control unit's instruction-register inputs,
//   datapath status and every datapath control output into one interface.
//
//   master : the control FSM (consumes opcode/funct/zero/mem_ready, drives
//            enables, mux selects, alu_cnt, illegal and state_dbg)
//   slave  : the datapath side (drives opcode/funct/zero/mem_ready)
// ---------------------------------------------------------------------------
interface mc_control_if;
  logic [5:0] opcode;     // instr[31:26]
  logic [5:0] funct;      // instr[5:0]
  logic       zero;       // ALU zero flag
  logic       mem_ready;  // memory access completes this cycle

  logic [3:0] alu_cnt;    // ALU operation code
  logic       alu_src_a;  // 0=PC, 1=regA
  logic [1:0] alu_src_b;  // 00=regB, 01=4, 10=imm, 11=imm<<2
  logic [1:0] pc_source;  // 00=ALU, 01=ALUOut, 10=jump target
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;     // 0=PC, 1=ALUOut
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;    // 0=rt, 1=rd
  logic       mem_to_reg; // 0=ALUOut, 1=MDR
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_cnt, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
           i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           illegal, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_cnt, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
           i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           illegal, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Main control unit of a multicycle MIPS. Sequences each instruction
//   through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and produces every
//   datapath enable, mux select and the 4-bit ALU operation code.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (forces RESET, outputs 0)
//   ctl    : mc_control_if.master (opcode, funct, zero, mem_ready in;
//            all control outputs, illegal and state_dbg out)
//
// Parameters
//   ILLEGAL_STICKY : 1 parks undecoded instructions in ILLEGAL until reset,
//                    0 treats them as NOP (back to FETCH)
//
// Build option
//   MC_CONTROL_BNE_EN : when defined, opcode 000101 (bne) decodes to BRANCH
//                       with pc_write = ~zero; otherwise it is illegal.
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master ctl
);

`ifdef MC_CONTROL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // state_dbg exposes this encoding directly; RESET must stay 0.
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  typedef struct packed {
    logic [3:0] alu_cnt;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // {valid, alu_cnt} for an R-type funct field.
  function automatic logic [4:0] r_type_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0000; // add
      6'b100010: return 5'b1_0001; // sub
      6'b100111: return 5'b1_0010; // nor -> not
      6'b000000: return 5'b1_0011; // sll
      6'b000010: return 5'b1_0100; // srl
      6'b100100: return 5'b1_0101; // and
      6'b100101: return 5'b1_0110; // or
      6'b101010: return 5'b1_0111; // slt
      default:   return 5'b0_0000;
    endcase
  endfunction

  // alu_cnt for the immediate-ALU opcodes (only reached for decoded ones).
  function automatic logic [3:0] i_type_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return 4'b0101;
      OP_ORI:  return 4'b0110;
      OP_SLTI: return 4'b0111;
      default: return 4'b0000; // addi
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [4:0] r_dec_q, r_dec_d;
  state_e     illegal_dest;
  logic       branch_take;

  assign illegal_dest = ILLEGAL_STICKY ? S_ILLEGAL : S_FETCH;
  assign r_dec_q      = r_type_alu(funct_q);
  assign r_dec_d      = r_type_alu(funct_d);

  // Next-state logic. opcode/funct are captured only in DECODE so that the
  // IR may change underneath the later states without effect.
  // NOTE: every variable gets a default at the top of the block; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (ctl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = ctl.opcode;
        funct_d = ctl.funct;
        case (ctl.opcode)
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_BNE:                           state_d = BneEn ? S_BRANCH : illegal_dest;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = illegal_dest;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (ctl.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (ctl.mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = r_dec_q[4] ? S_WB_R : illegal_dest;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_RESET;
    endcase
  end

  // Outputs are registered: decode them from the state being entered so
  // they line up with that state from its first cycle.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
      end
      S_DECODE:   ctrl_d.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_cnt   = r_dec_d[3:0];
      end
      S_WB_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_cnt   = i_type_alu(op_d);
      end
      S_WB_I: ctrl_d.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_cnt   = 4'b0001;
        ctrl_d.pc_source = 2'b01;
      end
      S_JUMP: begin
        ctrl_d.pc_source = 2'b10;
        ctrl_d.pc_write  = 1'b1;
      end
      S_ILLEGAL: ctrl_d.illegal = 1'b1;
      default:   ctrl_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // bne inverts the branch sense; only reachable when the option is built in.
  assign branch_take = (BneEn && op_q == OP_BNE) ? ~ctl.zero : ctl.zero;

  // ir_write and the FETCH/BRANCH pc_write depend on same-cycle inputs, so
  // they are qualified combinationally from the registered state.
  assign ctl.ir_write   = (state_q == S_FETCH) && ctl.mem_ready;
  assign ctl.pc_write   = ctrl_q.pc_write
                        | ((state_q == S_FETCH)  && ctl.mem_ready)
                        | ((state_q == S_BRANCH) && branch_take);
  assign ctl.alu_cnt    = ctrl_q.alu_cnt;
  assign ctl.alu_src_a  = ctrl_q.alu_src_a;
  assign ctl.alu_src_b  = ctrl_q.alu_src_b;
  assign ctl.pc_source  = ctrl_q.pc_source;
  assign ctl.i_or_d     = ctrl_q.i_or_d;
  assign ctl.mem_read   = ctrl_q.mem_read;
  assign ctl.mem_write  = ctrl_q.mem_write;
  assign ctl.reg_write  = ctrl_q.reg_write;
  assign ctl.reg_dst    = ctrl_q.reg_dst;
  assign ctl.mem_to_reg = ctrl_q.mem_to_reg;
  assign ctl.illegal    = ctrl_q.illegal;
  assign ctl.state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. A reference model expands each
//   instruction (opcode, funct, zero, stall counts) into the list of cycles
//   the control unit should produce, then the bench drives and compares
//   every output on every cycle. Honours MC_CONTROL_BNE_EN.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  // State numbering in the order the states are listed for the design.
  localparam int ST_RESET = 0,  ST_FETCH = 1,  ST_DECODE = 2, ST_MEM_ADDR = 3,
                 ST_MEM_RD = 4, ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC_R = 7,
                 ST_WB_R = 8,   ST_EXEC_I = 9, ST_WB_I = 10,  ST_BRANCH = 11,
                 ST_JUMP = 12,  ST_ILLEGAL = 13;

  typedef struct {
    int         st;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pcw, irw, iod, mr, mw, rw, rd, m2r, ill;
    logic       rdy, z;   // inputs driven during this cycle
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  mc_control_if bus ();

  mc_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  function automatic exp_t mk(input int st);
    exp_t r;
    r.st = st;  r.alu = 4'd0; r.sa = 1'b0; r.sb = 2'd0; r.ps = 2'd0;
    r.pcw = 1'b0; r.irw = 1'b0; r.iod = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
    r.rw = 1'b0;  r.rd = 1'b0;  r.m2r = 1'b0; r.ill = 1'b0;
    r.rdy = 1'($urandom);  // don't-care outside the memory-waiting states
    r.z   = 1'($urandom);
    return r;
  endfunction

  // R-type funct -> ALU code, straight from the operation table.
  function automatic int r_code(input logic [5:0] fn);
    logic [5:0] tbl [8] = '{6'b100000, 6'b100010, 6'b100111, 6'b000000,
                            6'b000010, 6'b100100, 6'b100101, 6'b101010};
    for (int k = 0; k < 8; k++) if (tbl[k] == fn) return k;
    return -1;
  endfunction

  // Reference model: expected cycle list for one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fs, input int ms, input int hold);
    exp_t r;
    int   code;
    bit   bad = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= fs; i++) begin
      r = mk(ST_FETCH); r.mr = 1; r.sb = 2'b01;
      r.rdy = (i == fs); r.irw = r.rdy; r.pcw = r.rdy;
      exp_q.push_back(r);
    end
    r = mk(ST_DECODE); r.sb = 2'b11; exp_q.push_back(r);
    case (op)
      6'b100011, 6'b101011: begin
        r = mk(ST_MEM_ADDR); r.sa = 1; r.sb = 2'b10; exp_q.push_back(r);
        for (int i = 0; i <= ms; i++) begin
          if (op == 6'b100011) begin r = mk(ST_MEM_RD); r.mr = 1; end
          else begin r = mk(ST_MEM_WR); r.mw = 1; end
          r.iod = 1; r.rdy = (i == ms); exp_q.push_back(r);
        end
        if (op == 6'b100011) begin
          r = mk(ST_MEM_WB); r.rw = 1; r.m2r = 1; exp_q.push_back(r);
        end
      end
      6'b000000: begin
        code = r_code(fn);
        r = mk(ST_EXEC_R); r.sa = 1; r.alu = (code < 0) ? 4'd0 : 4'(code);
        exp_q.push_back(r);
        if (code < 0) bad = 1'b1;
        else begin r = mk(ST_WB_R); r.rw = 1; r.rd = 1; exp_q.push_back(r); end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        r = mk(ST_EXEC_I); r.sa = 1; r.sb = 2'b10;
        r.alu = (op == 6'b001100) ? 4'd5 : (op == 6'b001101) ? 4'd6 :
                (op == 6'b001010) ? 4'd7 : 4'd0;
        exp_q.push_back(r);
        r = mk(ST_WB_I); r.rw = 1; exp_q.push_back(r);
      end
      6'b000100: begin
        r = mk(ST_BRANCH); r.sa = 1; r.alu = 4'd1; r.ps = 2'b01;
        r.z = z; r.pcw = z; exp_q.push_back(r);
      end
`ifdef MC_CONTROL_BNE_EN
      6'b000101: begin
        r = mk(ST_BRANCH); r.sa = 1; r.alu = 4'd1; r.ps = 2'b01;
        r.z = z; r.pcw = ~z; exp_q.push_back(r);
      end
`endif
      6'b000010: begin
        r = mk(ST_JUMP); r.ps = 2'b10; r.pcw = 1; exp_q.push_back(r);
      end
      default: bad = 1'b1;
    endcase
    if (bad)
      for (int i = 0; i < hold; i++) begin
        r = mk(ST_ILLEGAL); r.ill = 1; exp_q.push_back(r);
      end
  endtask

  // Entered at posedge+1: drive this cycle's inputs, compare at negedge,
  // return at posedge+1 of the following cycle.
  task automatic check_cycle(input string name, input int idx, input exp_t r);
    string t;
    bus.mem_ready = r.rdy;
    bus.zero      = r.z;
    @(negedge clk);
    t = $sformatf("%s.c%0d", name, idx);
    check({t, ".state"},     8'(bus.state_dbg),  8'(r.st));
    check({t, ".alu_cnt"},   8'(bus.alu_cnt),    8'(r.alu));
    check({t, ".alu_src_a"}, 8'(bus.alu_src_a),  8'(r.sa));
    check({t, ".alu_src_b"}, 8'(bus.alu_src_b),  8'(r.sb));
    check({t, ".pc_source"}, 8'(bus.pc_source),  8'(r.ps));
    check({t, ".pc_write"},  8'(bus.pc_write),   8'(r.pcw));
    check({t, ".ir_write"},  8'(bus.ir_write),   8'(r.irw));
    check({t, ".i_or_d"},    8'(bus.i_or_d),     8'(r.iod));
    check({t, ".mem_read"},  8'(bus.mem_read),   8'(r.mr));
    check({t, ".mem_write"}, 8'(bus.mem_write),  8'(r.mw));
    check({t, ".reg_write"}, 8'(bus.reg_write),  8'(r.rw));
    check({t, ".reg_dst"},   8'(bus.reg_dst),    8'(r.rd));
    check({t, ".mem_to_reg"},8'(bus.mem_to_reg), 8'(r.m2r));
    check({t, ".illegal"},   8'(bus.illegal),    8'(r.ill));
    @(posedge clk);
    #1;
  endtask

  // Asserts rst_n asynchronously, checks the immediate effect, releases and
  // checks the single RESET cycle. Returns at posedge+1 in FETCH.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, ".async.state"},     8'(bus.state_dbg), 8'd0);
    check({name, ".async.outs"},
          8'({bus.alu_cnt, bus.alu_src_a, bus.alu_src_b, bus.pc_source} != 0), 8'd0);
    check({name, ".async.mem_write"}, 8'(bus.mem_write), 8'd0);
    check({name, ".async.strobes"},
          8'({bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read,
              bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal}), 8'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_cycle({name, ".rst"}, 0, mk(ST_RESET));
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fs, input int ms, input int hold,
                           input int limit);
    build(op, fn, z, fs, ms, hold);
    bus.opcode = op;
    bus.funct  = fn;
    foreach (exp_q[i]) begin
      if (limit > 0 && i >= limit) break;
      check_cycle(name, i, exp_q[i]);
      if (exp_q[i].st == ST_DECODE) begin
        bus.opcode = 6'($urandom);  // IR changes after DECODE must be ignored
        bus.funct  = 6'($urandom);
      end
    end
    if (limit == 0 && exp_q[exp_q.size()-1].st == ST_ILLEGAL) do_reset({name, ".clr"});
  endtask

  initial begin
    logic [5:0] r_fns [7] = '{6'b100010, 6'b100111, 6'b000000, 6'b000010,
                              6'b100100, 6'b100101, 6'b101010};
    logic [5:0] ops [11] = '{6'b000000, 6'b000000, 6'b000000, 6'b100011, 6'b101011,
                             6'b001000, 6'b001100, 6'b001101, 6'b001010,
                             6'b000100, 6'b000010};
    logic [5:0] op, fn;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #2;
    do_reset("init");

    run_instr("add",     6'b000000, 6'b100000, 1'b0, 0, 0, 0, 0);
    run_instr("lw_stall",6'b100011, 6'b000000, 1'b0, 2, 3, 0, 0);
    run_instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, 0, 0);
    run_instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, 0, 0);
    foreach (r_fns[k]) run_instr($sformatf("rfn%0d", k), 6'b000000, r_fns[k], 1'b0, 0, 0, 0, 0);
    run_instr("addi", 6'b001000, 6'h15, 1'b0, 0, 0, 0, 0);
    run_instr("andi", 6'b001100, 6'h2a, 1'b0, 0, 0, 0, 0);
    run_instr("ori",  6'b001101, 6'h01, 1'b0, 1, 0, 0, 0);
    run_instr("slti", 6'b001010, 6'h3f, 1'b0, 0, 0, 0, 0);
    run_instr("sw",   6'b101011, 6'h00, 1'b0, 0, 1, 0, 0);
    run_instr("j",    6'b000010, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr("ill_op", 6'b111111, 6'h00, 1'b0, 0, 0, 20, 0);
    run_instr("ill_fn", 6'b000000, 6'b111111, 1'b0, 0, 0, 3, 0);
    run_instr("bne_z0", 6'b000101, 6'h00, 1'b0, 0, 0, 4, 0);
    run_instr("bne_z1", 6'b000101, 6'h00, 1'b1, 0, 0, 4, 0);

    // sw stalled in MEM_WR, then reset lands between clock edges.
    run_instr("sw_abort", 6'b101011, 6'h00, 1'b0, 0, 5, 0, 5);
    bus.mem_ready = 1'b0;
    check("sw_abort.pre.state",     8'(bus.state_dbg), 8'(ST_MEM_WR));
    check("sw_abort.pre.mem_write", 8'(bus.mem_write), 8'd1);
    do_reset("sw_abort");

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 10)];
      fn = (op == 6'b000000) ? r_fns[$urandom_range(0, 6)] : 6'($urandom);
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if (op == 6'b000000 && $urandom_range(0, 9) == 0) fn = 6'($urandom);
      run_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), 3, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
